// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types for the imem/dmem unified-port arbiter.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_I,
        GRANT_D
    } grant_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mem_req_t;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/imem_dmem_arbiter_select.sv
// Combinational grant pick: dmem has priority unless imem has been starved STARVE_MAX times.
module imem_dmem_arbiter_select
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
    parameter int CNT_W      = 3
) (
    input  logic             imem_req,
    input  logic             dmem_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output grant_t           grant
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    always_comb begin
        grant = GRANT_NONE;
        if (dmem_req && !(imem_req && starve_cnt == STARVE_LIM)) begin
            grant = GRANT_D;
        end else if (imem_req) begin
            grant = GRANT_I;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates fetch and data requests onto one registered memory port and steers responses back.
// Optional ARB_PERF_EN adds grant and imem-wait performance counters.
//
//  state   | meaning
//  IDLE    | no owner; pick a requester and register it onto mem_*
//  SERVE_I | imem owns the port; wait for mem_resp (may be dropped by flush)
//  SERVE_D | dmem owns the port; wait for mem_resp
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    input  logic        imem_flush,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
`ifdef ARB_PERF_EN
    ,
    output logic [31:0] perf_igrant,
    output logic [31:0] perf_dgrant,
    output logic [31:0] perf_iwait
`endif
);

    localparam int               CNT_W      = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    arb_state_t       state;
    mem_req_t         mem_req;
    logic [CNT_W-1:0] starve_cnt;
    logic             drop;
    logic             imem_req;
    logic             dmem_req;
    grant_t           grant;

    assign imem_req = |imem_rmask;
    assign dmem_req = |(dmem_rmask | dmem_wmask);

    imem_dmem_arbiter_select #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_arb_select (
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .starve_cnt (starve_cnt),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= '0;
            starve_cnt <= '0;
            drop       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant == GRANT_D) begin
                        mem_req <= '{addr: dmem_addr, rmask: dmem_rmask,
                                     wmask: dmem_wmask, wdata: dmem_wdata};
                        state   <= SERVE_D;
                        if (imem_req && starve_cnt != STARVE_LIM) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else if (grant == GRANT_I) begin
                        mem_req    <= '{addr: imem_addr, rmask: imem_rmask,
                                        wmask: 4'h0, wdata: 32'h0};
                        state      <= SERVE_I;
                        starve_cnt <= '0;
                    end
                end
                SERVE_D: begin
                    if (mem_resp) begin
                        mem_req.rmask <= 4'h0;
                        mem_req.wmask <= 4'h0;
                        state         <= IDLE;
                    end
                end
                SERVE_I: begin
                    // The flushed fetch still completes on the port; only its response is hidden.
                    if (mem_resp) begin
                        mem_req.rmask <= 4'h0;
                        mem_req.wmask <= 4'h0;
                        drop          <= 1'b0;
                        state         <= IDLE;
                    end else if (imem_flush) begin
                        drop <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr  = mem_req.addr;
    assign mem_rmask = mem_req.rmask;
    assign mem_wmask = mem_req.wmask;
    assign mem_wdata = mem_req.wdata;

    always_comb begin
        imem_resp  = (state == SERVE_I) && mem_resp && !drop && !imem_flush;
        dmem_resp  = (state == SERVE_D) && mem_resp;
        imem_rdata = imem_resp ? mem_rdata : 32'h0;
        dmem_rdata = dmem_resp ? mem_rdata : 32'h0;
    end

`ifdef ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_igrant <= 32'h0;
            perf_dgrant <= 32'h0;
            perf_iwait  <= 32'h0;
        end else begin
            if (state == IDLE && grant == GRANT_I) perf_igrant <= perf_igrant + 32'd1;
            if (state == IDLE && grant == GRANT_D) perf_dgrant <= perf_dgrant + 32'd1;
            if (imem_req && state != SERVE_I)      perf_iwait  <= perf_iwait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Scoreboard bench for imem_dmem_arbiter with a latency-programmable memory model.
module tb_imem_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic        imem_flush;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
`ifdef ARB_PERF_EN
    logic [31:0] perf_igrant;
    logic [31:0] perf_dgrant;
    logic [31:0] perf_iwait;
`endif

    imem_dmem_arbiter #(.STARVE_MAX(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_flush (imem_flush),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
`ifdef ARB_PERF_EN
        ,
        .perf_igrant (perf_igrant),
        .perf_dgrant (perf_dgrant),
        .perf_iwait  (perf_iwait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int lat      = 2;
    int stray_cnt = 0;
    int dresp_seen = 0;

    logic [31:0] imem_q[$];
    logic [31:0] dmem_q[$];
    logic        order_q[$];   // 1 = dmem, 0 = imem

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return a ^ 32'hC3C3_5A5A;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory model: responds lat cycles after a request becomes visible; drives junk data otherwise.
    initial begin
        int          cnt;
        int          stray_done;
        logic        pending;
        logic [31:0] req_addr;
        cnt = 0; stray_done = 0; pending = 1'b0; req_addr = '0;
        mem_resp  = 1'b0;
        mem_rdata = 32'hBAD0_0BAD;
        forever begin
            @(posedge clk); #1;
            mem_resp  = 1'b0;
            mem_rdata = 32'hBAD0_0BAD;
            if (!rst_n) begin
                pending = 1'b0;
            end else if (stray_cnt != stray_done) begin
                mem_resp  = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                stray_done++;
            end else if (pending) begin
                cnt--;
                if (cnt == 0) begin
                    mem_resp  = 1'b1;
                    mem_rdata = mem_model(req_addr);
                    pending   = 1'b0;
                end
            end else if ((mem_rmask | mem_wmask) != 4'h0) begin
                pending  = 1'b1;
                cnt      = lat;
                req_addr = mem_addr;
            end
        end
    end

    task automatic check_order(input logic port_obs);
        if (order_q.size() == 0) check("order_empty", 32'(order_q.size()), 32'd1);
        else check("order", 32'(port_obs), 32'(order_q.pop_front()));
    endtask

    // Response monitor / scoreboard pop side.
    initial begin
        forever begin
            @(posedge clk); #3;
            if (imem_resp) begin
                if (imem_q.size() == 0) check("imem_resp_unexp", 32'(imem_resp), 32'd0);
                else check("imem_rdata", imem_rdata, imem_q.pop_front());
                check_order(dmem_resp);
            end else begin
                check("imem_rdata_zero", imem_rdata, 32'h0);
            end
            if (dmem_resp) begin
                dresp_seen++;
                if (dmem_q.size() == 0) check("dmem_resp_unexp", 32'(dmem_resp), 32'd0);
                else check("dmem_rdata", dmem_rdata, dmem_q.pop_front());
                if (!imem_resp) check_order(dmem_resp);
            end else begin
                check("dmem_rdata_zero", dmem_rdata, 32'h0);
            end
        end
    end

    task automatic start_imem(input logic [31:0] a);
        imem_addr  = a;
        imem_rmask = 4'hF;
        imem_q.push_back(mem_model(a));
    endtask

    task automatic start_dmem(input logic [31:0] a, input logic [3:0] rm,
                              input logic [3:0] wm, input logic [31:0] wd);
        dmem_addr  = a;
        dmem_rmask = rm;
        dmem_wmask = wm;
        dmem_wdata = wd;
        dmem_q.push_back(mem_model(a));
    endtask

    task automatic wait_imem(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            n++;
            if (imem_resp) break;
        end
        if (!imem_resp) check("imem_timeout", 32'(imem_resp), 32'd1);
        imem_rmask = 4'h0;
    endtask

    task automatic wait_dmem(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (dmem_resp) break;
        end
        if (!dmem_resp) check("dmem_timeout", 32'(dmem_resp), 32'd1);
        dmem_rmask = 4'h0;
        dmem_wmask = 4'h0;
    endtask

    task automatic wait_grant(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #3;
            if (mem_rmask != 4'h0) break;
        end
        if (mem_rmask == 4'h0) check(tag, 32'(mem_rmask), 32'hF);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n2;
        int dbefore;
        imem_addr = '0; imem_rmask = '0; imem_flush = 1'b0;
        dmem_addr = '0; dmem_rmask = '0; dmem_wmask = '0; dmem_wdata = '0;

        // 1: reset with a pending fetch
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        order_q.push_back(1'b0);
        start_imem(32'hAAAA_A000);
        repeat (3) @(posedge clk);
        #3;
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_rmask", 32'(mem_rmask), 32'h0);
        check("rst_mem_wmask", 32'(mem_wmask), 32'h0);
        check("rst_imem_resp", 32'(imem_resp), 32'h0);
        check("rst_dmem_resp", 32'(dmem_resp), 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #3;
        check("t1_mem_addr", mem_addr, 32'hAAAA_A000);
        check("t1_mem_rmask", 32'(mem_rmask), 32'hF);
        wait_imem(20, n);

        // 2: imem only, latency 3
        lat = 3;
        @(posedge clk); #1;
        dbefore = dresp_seen;
        order_q.push_back(1'b0);
        start_imem(32'h0000_0040);
        wait_imem(20, n);
        check("t2_latency", 32'(n), 32'd4);
        check("t2_no_dresp", 32'(dresp_seen), 32'(dbefore));

        // 3: simultaneous requests, dmem store first
        lat = 2;
        @(posedge clk); #1;
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        fork
            begin start_dmem(32'h0000_0100, 4'h0, 4'h3, 32'hCAFE_F00D); wait_dmem(30); end
            begin start_imem(32'h0000_0500); wait_imem(40, n); end
            begin
                @(posedge clk); #3;
                check("t3_mem_addr", mem_addr, 32'h0000_0100);
                check("t3_mem_wmask", 32'(mem_wmask), 32'h3);
                check("t3_mem_rmask", 32'(mem_rmask), 32'h0);
                check("t3_mem_wdata", mem_wdata, 32'hCAFE_F00D);
            end
        join

        // 4: dmem held continuously, imem starved for STARVE_MAX grants
        @(posedge clk); #1;
        order_q.push_back(1'b1);
        order_q.push_back(1'b1);
        order_q.push_back(1'b1);
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        order_q.push_back(1'b1);
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    start_dmem(32'h0000_0200 + 32'(k * 4), k[0] ? 4'h0 : 4'hF,
                               k[0] ? 4'hF : 4'h0, 32'h1111_0000 + 32'(k));
                    wait_dmem(30);
                end
            end
            begin start_imem(32'h0000_0400); wait_imem(80, n2); end
        join
        check("t4_starve_cnt", 32'(dut.starve_cnt), 32'd0);

        // 5: flush during SERVE_I drops that response
        lat = 3;
        @(posedge clk); #1;
        imem_addr  = 32'h0000_2000;
        imem_rmask = 4'hF;
        wait_grant("t5_grant_timeout", 10);
        imem_flush = 1'b1;
        imem_addr  = 32'h0000_1000;
        order_q.push_back(1'b0);
        imem_q.push_back(mem_model(32'h0000_1000));
        @(posedge clk); #1;
        imem_flush = 1'b0;
        wait_imem(30, n);

        // 6: async reset mid-SERVE_D, then a stray mem_resp
        lat = 5;
        @(posedge clk); #1;
        dmem_addr  = 32'h0000_0300;
        dmem_rmask = 4'hF;
        wait_grant("t6_grant_timeout", 10);
        #1 rst_n = 1'b0;
        #1;
        check("t6_mem_addr", mem_addr, 32'h0);
        check("t6_mem_rmask", 32'(mem_rmask), 32'h0);
        check("t6_dmem_resp", 32'(dmem_resp), 32'h0);
        dmem_rmask = 4'h0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #3;
        stray_cnt++;
        @(posedge clk); #3;
        check("t6_stray_dresp", 32'(dmem_resp), 32'h0);
        check("t6_stray_iresp", 32'(imem_resp), 32'h0);
        check("t6_stray_rmask", 32'(mem_rmask), 32'h0);
        repeat (3) @(posedge clk);
        #3;

        check("imem_q_left", 32'(imem_q.size()), 32'd0);
        check("dmem_q_left", 32'(dmem_q.size()), 32'd0);
        check("order_q_left", 32'(order_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
